piso_transmitter: RTL and testbench
===================================

PISO_TRANSMITTER -- requirements
Module: piso_transmitter

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits; SHALL be at least 2.
REQ-002 Parameter DIVISOR, default 4: clock cycles each serial bit is held; SHALL be at least 1.
REQ-003 Port clock, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port data, input, WIDTH: word to transmit, sampled only on accept.
REQ-006 Port valid, input, 1: sender has a word on data.
REQ-007 Port left, input, 1: bit order, sampled on accept; 1 = MSB first, 0 = LSB first.
REQ-008 Port ready, output, 1: block can accept a word this cycle.
REQ-009 Port serial, output, 1: serial line; the line idles high.
REQ-010 Port busy, output, 1: a frame is in progress.
REQ-011 Port done, output, 1: one-cycle pulse when a frame completes.

Function
REQ-012 States SHALL be IDLE, START, DATA, PARITY and STOP; PARITY exists only per REQ-026.
REQ-013 ready SHALL equal (state==IDLE); an accept SHALL occur when valid and ready are both 1 at a clock edge.
REQ-014 On accept, the block SHALL capture data and left into an internal shift register and go to START.
REQ-015 serial SHALL go low on the first cycle after accept: 1-cycle latency.
REQ-016 Each bit (start, data, parity, stop) SHALL be held for exactly DIVISOR cycles, timed by a bit-tick counter.
REQ-017 Start bit SHALL be 0, data bits SHALL follow in the captured order, and the stop bit SHALL be 1.
REQ-018 DATA SHALL last exactly WIDTH bit periods, counted by a bit counter sized $clog2(WIDTH+1).
REQ-019 On the last cycle of STOP, the next state SHALL be IDLE and done SHALL be 1 for exactly that one cycle; busy SHALL be 1 in every non-IDLE state.
REQ-020 Frame length SHALL be (WIDTH+2)*DIVISOR cycles without parity, or (WIDTH+3)*DIVISOR cycles with parity.
REQ-021 The minimum gap between frames SHALL be one IDLE cycle with serial=1, in which a new accept is allowed.
REQ-022 While busy, valid SHALL be ignored and changes on data and left SHALL NOT affect the frame in flight.
REQ-023 In IDLE, serial SHALL be 1 whatever the value of valid.

Reset
REQ-024 When reset=1 at a clock edge, from that edge: state=IDLE, serial=1, ready=1, busy=0, done=0, and the counters and shift register SHALL be 0.
REQ-025 Reset mid-frame SHALL abort the frame without a done pulse; reset SHALL take priority over accept on the same edge.

Configuration
REQ-026 Macro PISO_TRANSMITTER_PARITY_EN: when defined, a PARITY state SHALL follow DATA and send the even-parity bit (^data as captured) for DIVISOR cycles before STOP; when undefined, DATA SHALL go directly to STOP and no parity logic SHALL be built.

Structure
REQ-027 Package piso_transmitter_pkg SHALL hold the state enum typedef (tx_state_t) and the constants IDLE_LEVEL=1'b1, START_LEVEL=1'b0 and STOP_LEVEL=1'b1.
REQ-028 Sub-module bit_timer SHALL count 0..DIVISOR-1, pulse tick on DIVISOR-1, and clear on a restart input asserted at accept.
REQ-029 Outputs SHALL be registered, except ready, which is decoded from the state register.

Verification (WIDTH=8, DIVISOR=4, parity off unless noted)
REQ-030 Reset held for 2 cycles, then released -> serial=1, ready=1, busy=0, done=0; these SHALL stay stable with valid=0.
REQ-031 Accept 8'hA5 with left=0 -> serial is 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles; done pulses once on the 40th cycle after accept.
REQ-032 Accept 8'h01 with left=1 -> the data bits are seven 0s then a 1; the same word with left=0 -> a 1 then seven 0s.
REQ-033 Accept 8'hF0; 10 cycles later drive data=8'h0F, valid=1 and left=1 -> the frame continues 0,0,0,0,1,1,1,1 LSB-first, and 8'h0F is accepted in the IDLE cycle right after done.
REQ-034 Assert reset at cycle 15 of a frame -> on the next cycle serial=1 and ready=1; no done pulse occurs.
REQ-035 With PISO_TRANSMITTER_PARITY_EN defined, accept 8'h07 -> the parity bit is 1, the frame is 44 cycles and done arrives at cycle 44; with 8'h03 -> the parity bit is 0.

Source files
------------

// File: rtl/piso_transmitter_pkg.sv
// rtl/piso_transmitter_pkg.sv - shared state type and line levels for piso_transmitter (PISO_TRANSMITTER_PARITY_EN adds PARITY)
package piso_transmitter_pkg;

  // PARITY only exists when the parity option is built
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef PISO_TRANSMITTER_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/piso_transmitter_bit_timer.sv
// rtl/piso_transmitter_bit_timer.sv - bit period counter, ticks on the last cycle of each bit
module bit_timer #(
  parameter int DIVISOR = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick,
  output logic last_next
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(DIVISOR - 1));

  // last_next: the coming cycle will be the final cycle of the current bit
  generate
    if (DIVISOR == 1) begin : g_div1
      assign last_next = 1'b1;
    end else begin : g_divn
      assign last_next = !restart && en && (count == CW'(DIVISOR - 2));
    end
  endgenerate

  // free-running 0..DIVISOR-1 while enabled, cleared on restart
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (en) begin
      if (tick) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/piso_transmitter.sv
// rtl/piso_transmitter.sv - framed parallel-in serial-out transmitter; PISO_TRANSMITTER_PARITY_EN adds an even-parity bit
module piso_transmitter
  import piso_transmitter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIVISOR = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  input  logic             left,
  output logic             ready,
  output logic             serial,
  output logic             busy,
  output logic             done
);

  localparam int BCW = $clog2(WIDTH + 1);

  tx_state_t        state_q, state_n;
  logic [WIDTH-1:0] shreg_q, shreg_n;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_n;
  logic             left_q, left_n;
  logic             serial_n, busy_n, done_n;
  logic             accept;
  logic             tick, last_next;
  logic             next_bit;
  logic [WIDTH-1:0] shifted;
`ifdef PISO_TRANSMITTER_PARITY_EN
  logic             par_q, par_n;
`endif

  assign ready  = (state_q == IDLE);
  assign accept = valid && ready;

  // next data bit comes from the end selected at accept; the register shifts toward that end
  assign next_bit = left_q ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shifted  = left_q ? (shreg_q << 1) : (shreg_q >> 1);

  bit_timer #(.DIVISOR(DIVISOR)) u_bit_timer (
    .clock     (clock),
    .reset     (reset),
    .en        (state_q != IDLE),
    .restart   (accept),
    .tick      (tick),
    .last_next (last_next)
  );

  // next-state and next-output decode; serial/busy/done are registered from these
  always_comb begin
    state_n   = state_q;
    shreg_n   = shreg_q;
    bit_cnt_n = bit_cnt_q;
    left_n    = left_q;
    serial_n  = serial;
`ifdef PISO_TRANSMITTER_PARITY_EN
    par_n     = par_q;
`endif
    case (state_q)
      IDLE: begin
        serial_n = IDLE_LEVEL;
        if (valid) begin
          state_n   = START;
          serial_n  = START_LEVEL;
          shreg_n   = data;
          left_n    = left;
          bit_cnt_n = '0;
`ifdef PISO_TRANSMITTER_PARITY_EN
          par_n     = ^data;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_n  = DATA;
          serial_n = next_bit;
          shreg_n  = shifted;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == BCW'(WIDTH - 1)) begin
`ifdef PISO_TRANSMITTER_PARITY_EN
            state_n  = PARITY;
            serial_n = par_q;
`else
            state_n  = STOP;
            serial_n = STOP_LEVEL;
`endif
          end else begin
            bit_cnt_n = bit_cnt_q + 1'b1;
            serial_n  = next_bit;
            shreg_n   = shifted;
          end
        end
      end
`ifdef PISO_TRANSMITTER_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_n  = STOP;
          serial_n = STOP_LEVEL;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_n  = IDLE;
          serial_n = IDLE_LEVEL;
        end
      end
      default: begin
        state_n  = IDLE;
        serial_n = IDLE_LEVEL;
      end
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == STOP) && last_next;
  end

  // state and datapath registers; reset wins over any accept on the same edge
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      left_q    <= 1'b0;
      serial    <= IDLE_LEVEL;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef PISO_TRANSMITTER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_n;
      shreg_q   <= shreg_n;
      bit_cnt_q <= bit_cnt_n;
      left_q    <= left_n;
      serial    <= serial_n;
      busy      <= busy_n;
      done      <= done_n;
`ifdef PISO_TRANSMITTER_PARITY_EN
      par_q     <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_piso_transmitter.sv
// tb/tb_piso_transmitter.sv - randomized self-checking bench for piso_transmitter against a frame model
module tb_piso_transmitter;

  localparam int W = 8;
  localparam int D = 4;
`ifdef PISO_TRANSMITTER_PARITY_EN
  localparam int NB = W + 3;
`else
  localparam int NB = W + 2;
`endif
  localparam int L = NB * D;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] data  = '0;
  logic         valid = 1'b0;
  logic         left  = 1'b0;
  logic         ready, serial, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  piso_transmitter #(.WIDTH(W), .DIVISOR(D)) dut (
    .clock  (clock),
    .reset  (reset),
    .data   (data),
    .valid  (valid),
    .left   (left),
    .ready  (ready),
    .serial (serial),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // expected line levels of one frame, one entry per bit
  function automatic void build_bits(input logic [W-1:0] w, input bit l, output logic bits [NB]);
    bits[0] = 1'b0;
    for (int i = 0; i < W; i++) bits[1 + i] = l ? w[W-1-i] : w[i];
`ifdef PISO_TRANSMITTER_PARITY_EN
    bits[W+1] = ^w;
`endif
    bits[NB-1] = 1'b1;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_serial"}, serial, 1'b1);
    chk({tag, "_ready"}, ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  // called at a negedge in IDLE: present a word for the next edge
  task automatic start_frame(input logic [W-1:0] w, input bit l);
    data  = w;
    left  = l;
    valid = 1'b1;
  endtask

  // follows one accepted frame cycle by cycle, scrambling inputs while busy,
  // then checks the IDLE gap; chain keeps a new word pending so it is taken in that gap
  task automatic check_frame(input logic [W-1:0] w, input bit l, input bit chain,
                             input logic [W-1:0] nw, input bit nl);
    logic bits [NB];
    build_bits(w, l, bits);
    for (int k = 1; k <= L; k++) begin
      @(negedge clock);
      chk("serial", serial, bits[(k-1)/D]);
      chk("busy", busy, 1'b1);
      chk("ready", ready, 1'b0);
      chk("done", done, (k == L));
      if (chain && k >= 10) begin
        data  = nw;
        left  = nl;
        valid = 1'b1;
      end else begin
        data  = W'($urandom);
        left  = 1'($urandom);
        valid = (k < L) ? 1'($urandom) : 1'b0;
      end
    end
    @(negedge clock);
    check_idle("gap");
  endtask

  logic [W-1:0] w, nw;
  bit           l, nl, chain;

  initial begin
    // reset held two cycles, then released with valid low
    repeat (2) @(negedge clock);
    check_idle("in_reset");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_idle("post_reset");
    end

    // directed frames
    start_frame(8'hA5, 1'b0);
    check_frame(8'hA5, 1'b0, 1'b0, '0, 1'b0);
    start_frame(8'h01, 1'b1);
    check_frame(8'h01, 1'b1, 1'b0, '0, 1'b0);
    start_frame(8'h01, 1'b0);
    check_frame(8'h01, 1'b0, 1'b0, '0, 1'b0);

    // word offered mid-frame is held off until the gap after done
    start_frame(8'hF0, 1'b0);
    check_frame(8'hF0, 1'b0, 1'b1, 8'h0F, 1'b1);
    check_frame(8'h0F, 1'b1, 1'b0, '0, 1'b0);

`ifdef PISO_TRANSMITTER_PARITY_EN
    start_frame(8'h07, 1'b0);
    check_frame(8'h07, 1'b0, 1'b0, '0, 1'b0);
    start_frame(8'h03, 1'b1);
    check_frame(8'h03, 1'b1, 1'b0, '0, 1'b0);
`endif

    // random frames, some back-to-back
    w = W'($urandom);
    l = 1'($urandom);
    start_frame(w, l);
    for (int f = 0; f < 12; f++) begin
      chain = 1'($urandom);
      nw    = W'($urandom);
      nl    = 1'($urandom);
      check_frame(w, l, chain, nw, nl);
      if (!chain) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clock);
          check_idle("rand_idle");
        end
        nw = W'($urandom);
        nl = 1'($urandom);
        start_frame(nw, nl);
      end
      w = nw;
      l = nl;
    end
    check_frame(w, l, 1'b0, '0, 1'b0);

    // reset in the middle of a frame aborts it with no done
    start_frame(8'h3C, 1'b1);
    begin
      logic bits [NB];
      build_bits(8'h3C, 1'b1, bits);
      for (int k = 1; k <= 15; k++) begin
        @(negedge clock);
        chk("abort_serial", serial, bits[(k-1)/D]);
        valid = 1'b0;
      end
    end
    reset = 1'b1;
    @(negedge clock);
    check_idle("abort_reset");
    reset = 1'b0;
    for (int i = 0; i < L + 5; i++) begin
      @(negedge clock);
      check_idle("after_abort");
    end

    // reset beats an accept on the same edge
    reset = 1'b1;
    start_frame(8'h55, 1'b0);
    @(negedge clock);
    check_idle("reset_vs_accept");
    valid = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_idle("reset_vs_accept_hold");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
